// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
// Holds size encodings, FSM state type, lane-mask and alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Byte enables for an access; size 11 behaves as a word.
    // Half and word masks ignore the low address bits, which
    // gives force-alignment for free when trapping is off.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << a;
            SZ_H:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = a[0];
            default: r = (a != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bundle between core and dmem_ctrl.
// master = core side, slave = memory side.
interface dmem_ctrl_if;

    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: extracts and extends the addressed lanes of a word.
// Ports: word_i raw word, addr_i byte offset, size_i, unsigned_i; data_o result.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] b_sh;
    logic [31:0] h_sh;
    logic [7:0]  b;
    logic [15:0] h;

    assign b_sh = word_i >> {addr_i, 3'b000};
    assign h_sh = word_i >> {addr_i[1], 4'b0000};
    assign b    = b_sh[7:0];
    assign h    = h_sh[15:0];

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_B: data_o = unsigned_i ? {24'b0, b}
                                      : {{24{b[7]}}, b};
            SZ_H: data_o = unsigned_i ? {16'b0, h}
                                      : {{16{h[15]}}, h};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding data-memory responder with fixed latency.
// Ports: clk, rst (async high), bus (dmem_ctrl_if.slave).
// Macro DMEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of aligning.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic        clk,
    input logic        rst,
    dmem_ctrl_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT =
        CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    a_q;
    logic [AW-1:0] idx_q;
    logic          fault_q;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          accept;
    logic [AW-1:0] req_idx;
    logic          req_fault;
    logic [3:0]    req_be;
    logic [31:0]   wd_rep;
    logic [31:0]   ld_data;
    logic          unused_addr;

    assign accept  = bus.req_valid & (state_q == IDLE);
    assign req_idx = bus.req_addr[AW+1:2];
    assign req_be  = lane_mask(bus.req_size, bus.req_addr[1:0]);
    assign unused_addr = ^bus.req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign req_fault = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign req_fault = 1'b0;
`endif

    // Replicate store data so each enabled lane sees its low bits.
    always_comb begin
        case (bus.req_size)
            SZ_B:    wd_rep = {4{bus.req_wdata[7:0]}};
            SZ_H:    wd_rep = {2{bus.req_wdata[15:0]}};
            default: wd_rep = bus.req_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            a_q     <= 2'b00;
            idx_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                a_q     <= bus.req_addr[1:0];
                idx_q   <= req_idx;
                fault_q <= req_fault;
            end
        end
    end

    // Store commits at the accept edge; an edge under reset never writes.
    always_ff @(posedge clk) begin
        if (!rst && accept && bus.req_we && !req_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (req_be[i]) begin
                    mem_q[req_idx][8*i +: 8] <= wd_rep[8*i +: 8];
                end
            end
        end
    end

    // WAIT lasts LATENCY-1 cycles: counter starts at LATENCY-2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY >= 2) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    dmem_load_align u_align (
        .word_i     (mem_q[idx_q]),
        .addr_i     (a_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_fault = (state_q == RESP) & fault_q;
    assign bus.rsp_rdata =
        ((state_q == RESP) && !we_q && !fault_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl.
// Expectations queued at accept, popped on each rsp_valid pulse.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    dmem_ctrl_if bus();

    dmem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   pulse_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.rsp_valid === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", bus.rsp_rdata, e.d);
                chk("fault", {31'b0, bus.rsp_fault}, {31'b0, e.f});
                chk("latency", 32'(cyc - e.acc), 32'(LAT - 1));
            end
        end
    end

    task automatic req(input logic        we,
                       input logic [1:0]  sz,
                       input logic        uns,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] ed,
                       input logic        ef,
                       input bit          keep);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.d   = ed;
        e.f   = ef;
        e.acc = cyc;
        sb.push_back(e);
        chk("ready_busy", {31'b0, bus.req_ready}, 32'd0);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int p0;
        logic [31:0] mis_d;
        logic        mis_f;

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_fault", {31'b0, bus.rsp_fault}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        req(1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        req(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        req(0, SZ_B, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0);
        req(0, SZ_B, 1, 32'h13, 32'h0, 32'h000000DE, 0, 0);
        req(0, SZ_H, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 0);
        req(1, SZ_B, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, 0);
        req(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_d = 32'h0;
        mis_f = 1'b1;
`else
        mis_d = 32'hDEAD55EF;
        mis_f = 1'b0;
`endif
        req(0, SZ_W, 0, 32'h12, 32'h0, mis_d, mis_f, 0);
        req(0, SZ_W, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0);
        req(0, 2'b11, 1, 32'h10, 32'h0, 32'hDEAD55EF, 0, 0);
        drain();
        chk("idle_rdata", bus.rsp_rdata, 32'd0);

        p0 = pulses;
        pulse_cyc.delete();
        req(1, SZ_W, 0, 32'h14, 32'h11223344, 32'h0, 0, 1);
        req(0, SZ_W, 0, 32'h14, 32'h0, 32'h11223344, 0, 1);
        req(0, SZ_H, 1, 32'h16, 32'h0, 32'h00001122, 0, 1);
        bus.req_valid = 1'b0;
        drain();
        chk("burst_pulses", 32'(pulses - p0), 32'd3);
        if (pulse_cyc.size() >= 3) begin
            chk("gap01", 32'(pulse_cyc[1] - pulse_cyc[0]),
                32'(LAT + 1));
            chk("gap12", 32'(pulse_cyc[2] - pulse_cyc[1]),
                32'(LAT + 1));
        end else begin
            chk("gap_count", 32'(pulse_cyc.size()), 32'd3);
        end

        bus.req_we    = 1'b0;
        bus.req_size  = SZ_W;
        bus.req_addr  = 32'h10;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("wait_busy", {31'b0, bus.req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_valid", {31'b0, bus.rsp_valid}, 32'd0);
        p0 = pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        chk("rst_no_rsp", 32'(pulses - p0), 32'd0);

        req(0, SZ_W, 0, 32'h10 + 4 * DEPTH, 32'h0,
            32'hDEAD55EF, 0, 0);
        req(1, SZ_B, 0, 32'h13 + 4 * DEPTH, 32'h77,
            32'h0, 0, 0);
        req(0, SZ_W, 0, 32'h10, 32'h0, 32'h77AD55EF, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
